pingpong_fmap_buffer: RTL

//  Double-buffered (ping-pong) feature-map store between a layer producer (port A, write) and consumer (port B, read).
//  Two banks of MEM_SIZE words each. The producer fills one bank while the consumer drains the other.

---
 rtl/pingpong_fmap_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pingpong_fmap_buffer.sv
// Two-bank ping-pong feature-map store; ownership moves between producer and consumer via Fill_Done/Drain_Done.
// Optional macro PINGPONG_PARITY_EN stores an even-parity bit per word and flags mismatches on read.
module pingpong_fmap_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_SIZE     = 28*28,
    parameter int READ_LATENCY = 1,
    localparam int ADDR_WIDTH  = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_Input_A,
    input  logic [ADDR_WIDTH-1:0] Address_A,
    input  logic                  Enable_Write_A,
    input  logic                  Fill_Done,
    output logic                  Fill_Ready,
    input  logic [ADDR_WIDTH-1:0] Address_B,
    input  logic                  Enable_Read_B,
    input  logic                  Drain_Done,
    output logic                  Drain_Ready,
    output logic [DATA_WIDTH-1:0] Data_Output_B,
    output logic                  Valid_Output_B,
    output logic                  Parity_Error,
    output logic                  Fill_Bank,
    output logic                  Drain_Bank,
    output logic [1:0]            Bank_Count,
    output logic [1:0]            Error_Flags
);

`ifdef PINGPONG_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction
`else
    localparam int WORD_W = DATA_WIDTH;
`endif

    typedef enum logic {FREE = 1'b0, FULL = 1'b1} bank_state_t;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    logic        fp_q, fp_d;
    logic        dp_q, dp_d;
    logic [1:0]  err_q, err_d;

    logic [WORD_W-1:0] mem [2][MEM_SIZE];
    logic [WORD_W-1:0] wr_word;

    logic fill_ready, drain_ready;
    logic wr_fire, rd_fire, fill_fire, drain_fire;

    assign fill_ready  = (bank_q[fp_q] == FREE);
    assign drain_ready = (bank_q[dp_q] == FULL);
    assign wr_fire     = Enable_Write_A && fill_ready;
    assign rd_fire     = Enable_Read_B && drain_ready;
    assign fill_fire   = Fill_Done && fill_ready;
    assign drain_fire  = Drain_Done && drain_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= FREE;
            bank_q[1] <= FREE;
            fp_q      <= 1'b0;
            dp_q      <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            fp_q      <= fp_d;
            dp_q      <= dp_d;
            err_q     <= err_d;
        end
    end

    // Fill and drain never target the same bank in one cycle: fp==dp leaves only one side ready.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        fp_d      = fp_q;
        dp_d      = dp_q;
        err_d     = err_q;
        if (fill_fire) begin
            bank_d[fp_q] = FULL;
            fp_d         = ~fp_q;
        end
        if (drain_fire) begin
            bank_d[dp_q] = FREE;
            dp_d         = ~dp_q;
        end
        if ((Enable_Write_A || Fill_Done) && !fill_ready)
            err_d[0] = 1'b1;
        if ((Enable_Read_B || Drain_Done) && !drain_ready)
            err_d[1] = 1'b1;
    end

`ifdef PINGPONG_PARITY_EN
    assign wr_word = {even_parity(Data_Input_A), Data_Input_A};
`else
    assign wr_word = Data_Input_A;
`endif

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[fp_q][Address_A] <= wr_word;
    end

    // Stage p0: bank and address sampled at the accepting edge.
    logic              vld_p0;
    logic [WORD_W-1:0] word_p0;
    logic              out_vld;
    logic [WORD_W-1:0] out_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            word_p0 <= '0;
        end else begin
            vld_p0 <= rd_fire;
            if (rd_fire)
                word_p0 <= mem[dp_q][Address_B];
        end
    end

    // Stage p1: optional output register for READ_LATENCY == 2.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              vld_p1;
            logic [WORD_W-1:0] word_p1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p1  <= 1'b0;
                    word_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0)
                        word_p1 <= word_p0;
                end
            end

            assign out_vld  = vld_p1;
            assign out_word = word_p1;
        end else begin : g_lat1
            assign out_vld  = vld_p0;
            assign out_word = word_p0;
        end
    endgenerate

    assign Data_Output_B  = out_word[DATA_WIDTH-1:0];
    assign Valid_Output_B = out_vld;
`ifdef PINGPONG_PARITY_EN
    assign Parity_Error   = out_vld && (^out_word);
`else
    assign Parity_Error   = 1'b0;
`endif

    assign Fill_Ready  = fill_ready;
    assign Drain_Ready = drain_ready;
    assign Fill_Bank   = fp_q;
    assign Drain_Bank  = dp_q;
    assign Bank_Count  = {1'b0, bank_q[0] == FULL} + {1'b0, bank_q[1] == FULL};
    assign Error_Flags = err_q;

endmodule
